gray_roi_sequencer: RTL and testbench
=====================================

Name: gray_roi_sequencer

Overview:
- Frame/line sequencer in front of the RGB-to-gray converter in the pupil-search pipeline.
- Tracks pixel coordinates from the camera frame-valid/data-valid stream.
- Gates the converter's data-valid to a programmable region of interest (ROI), and emits start-of-frame/end-of-frame markers, a frame counter and a geometry-error flag.
- ROI configuration is taken through a valid/ready handshake and applied only at frame boundaries.

Parameters:
- H_ACTIVE, 640, pixels per line.
- V_ACTIVE, 480, lines per frame.
- CW, 11, coordinate width. Must satisfy 2^CW > max(H_ACTIVE, V_ACTIVE).

Ports:
- iCLK  in  1  system clock, rising edge.
- iRST  in  1  asynchronous, active-low reset.
- iFVAL  in  1  camera frame valid.
- iDVAL  in  1  camera pixel valid, qualified by iFVAL.
- iPIX  in  30  {R[9:0],G[9:0],B[9:0]} pixel data, valid with iDVAL.
- iCFG_VALID  in  1  ROI write request.
- iCFG_X0, iCFG_X1, iCFG_Y0, iCFG_Y1  in  CW each  inclusive ROI bounds.
- oCFG_READY  out  1  shadow ROI register empty; write accepted when iCFG_VALID & oCFG_READY.
- oGRAY_DVAL  out  1  drives the converter's data-valid input.
- oPIX  out  30  iPIX registered, aligned with oGRAY_DVAL; drives the converter's R/G/B inputs.
- oX, oY  out  CW each  coordinate of the pixel on oPIX.
- oSOF  out  1  one-cycle pulse at frame start.
- oEOF  out  1  one-cycle pulse at a correctly sized frame end.
- oFRAME_CNT  out  16  count of good frames, wraps at 0xFFFF->0.
- oERR  out  1  sticky geometry error.

Behaviour:
- Reset (async, iRST=0) forces all outputs to 0, except oCFG_READY=1.
  - Active ROI resets to X0=0, X1=H_ACTIVE-1, Y0=0, Y1=V_ACTIVE-1.
  - Shadow register resets to empty. Internal counters reset to 0. State resets to IDLE.
  - The registered previous iFVAL resets to 1, so an iFVAL already high at reset release never starts a frame. The first frame starts on a fresh rising edge.
- States: IDLE, FRAME, OVF.
- IDLE:
  - iDVAL is ignored.
  - On an iFVAL rising edge (iFVAL=1, previous iFVAL=0):
    - Copy the shadow into the active ROI if the shadow is full, then mark the shadow empty.
    - Clear X, Y and the pixel count.
    - Pulse oSOF on the next cycle and enter FRAME.
  - An iDVAL on the rising-edge cycle is pixel (0,0).
- FRAME:
  - Each iDVAL=1 cycle registers iPIX->oPIX and X->oX, Y->oY.
  - oGRAY_DVAL = (X0<=X<=X1) && (Y0<=Y<=Y1), registered. Latency is 1 cycle from iDVAL.
  - X increments. At X==H_ACTIVE-1, X wraps to 0 and Y increments.
  - An iDVAL with Y==V_ACTIVE (too many pixels) sets oERR, suppresses oGRAY_DVAL and enters OVF.
  - On an iFVAL falling edge:
    - If the count equals H_ACTIVE*V_ACTIVE: pulse oEOF and increment oFRAME_CNT.
    - Otherwise (short frame): set oERR with no oEOF and no count.
    - Go to IDLE.
  - An iDVAL on the falling-edge cycle is not counted, because iFVAL=0 disqualifies it.
- OVF:
  - All iDVAL is ignored and oGRAY_DVAL=0.
  - On an iFVAL falling edge, go to IDLE with no oEOF.
- oERR is cleared only by reset.
- Config handshake:
  - On iCFG_VALID & oCFG_READY, capture the four bounds into the shadow and drive oCFG_READY=0 from the next cycle.
  - oCFG_READY returns to 1 the cycle after the shadow is applied at an SOF.
  - A write accepted on the same cycle as an iFVAL rising edge is not applied to that frame. The shadow was empty at sampling, so the write applies at the next SOF.
  - Bounds with X0>X1 or Y0>Y1 are accepted as-is and give an empty window: no oGRAY_DVAL for that frame.
  - Bounds at or beyond H_ACTIVE/V_ACTIVE are clipped naturally by the coordinate range.
- Reset mid-frame: immediate return to reset values. The partial frame is discarded.
- Gaps in iDVAL within iFVAL (blanking) hold X/Y unchanged and drive oGRAY_DVAL=0.

Test Plan:
- Default ROI with H_ACTIVE=4, V_ACTIVE=2 (test parameters), 8 contiguous iDVAL pulses -> 8 oGRAY_DVAL pulses with oX,oY = (0,0)..(3,1); oSOF once; oEOF once; oFRAME_CNT=1; oERR=0.
- Same geometry, ROI write X0=1,X1=2,Y0=1,Y1=1 during frame 1 -> oCFG_READY=0 until frame 2 SOF; frame 1 passes 8 pixels; frame 2 passes exactly (1,1),(2,1).
- Short frame, 7 pixels then iFVAL falls -> no oEOF; oFRAME_CNT unchanged; oERR=1 and stays 1 through the next good frame.
- Long frame, 9 pixels -> 9th pixel not forwarded; state OVF; no oEOF on iFVAL fall; oERR=1.
- iFVAL held high across reset release, then fall and rise -> no oSOF until the fresh rise; the first counted frame starts there.
- Reset asserted at pixel 5 of a frame -> all outputs zero, oCFG_READY=1, ROI back to default; next full frame gives oFRAME_CNT=1.

Source files
------------

// File: rtl/gray_roi_sequencer_if.sv
// gray_roi_sequencer_if
//   Camera stream, ROI configuration handshake and converter-side outputs
//   of the gray ROI sequencer, bundled as one interface.
//   master : camera / config source (drives i*, observes o*)
//   slave  : sequencer (observes i*, drives o*)
//   Signals:
//     iFVAL, iDVAL, iPIX       camera frame valid, pixel valid, {R,G,B} pixel
//     iCFG_VALID, iCFG_X0/X1/Y0/Y1, oCFG_READY   ROI write handshake
//     oGRAY_DVAL, oPIX, oX, oY converter data-valid, pixel and coordinate
//     oSOF, oEOF, oFRAME_CNT, oERR   frame markers, good-frame count, error
interface gray_roi_sequencer_if #(
  parameter int CW = 11
);
  logic          iFVAL;
  logic          iDVAL;
  logic [29:0]   iPIX;
  logic          iCFG_VALID;
  logic [CW-1:0] iCFG_X0;
  logic [CW-1:0] iCFG_X1;
  logic [CW-1:0] iCFG_Y0;
  logic [CW-1:0] iCFG_Y1;
  logic          oCFG_READY;
  logic          oGRAY_DVAL;
  logic [29:0]   oPIX;
  logic [CW-1:0] oX;
  logic [CW-1:0] oY;
  logic          oSOF;
  logic          oEOF;
  logic [15:0]   oFRAME_CNT;
  logic          oERR;

  modport master (
    output iFVAL, iDVAL, iPIX, iCFG_VALID, iCFG_X0, iCFG_X1, iCFG_Y0, iCFG_Y1,
    input  oCFG_READY, oGRAY_DVAL, oPIX, oX, oY, oSOF, oEOF, oFRAME_CNT, oERR
  );

  modport slave (
    input  iFVAL, iDVAL, iPIX, iCFG_VALID, iCFG_X0, iCFG_X1, iCFG_Y0, iCFG_Y1,
    output oCFG_READY, oGRAY_DVAL, oPIX, oX, oY, oSOF, oEOF, oFRAME_CNT, oERR
  );
endinterface

// File: rtl/gray_roi_sequencer.sv
// gray_roi_sequencer
//   Tracks pixel coordinates of the camera stream, gates the RGB-to-gray
//   converter's data-valid to a programmable region of interest, and emits
//   SOF/EOF pulses, a good-frame counter and a sticky geometry-error flag.
//   ROI writes land in a shadow register and take effect at the next SOF.
//   Ports:
//     iCLK  system clock, rising edge
//     iRST  asynchronous active-low reset
//     bus   gray_roi_sequencer_if slave modport (stream, config, outputs)
//
//   state  | meaning
//   IDLE   | between frames, waiting for an iFVAL rising edge
//   FRAME  | inside a frame, counting and forwarding pixels
//   OVF    | frame exceeded its size, ignoring pixels until iFVAL falls
module gray_roi_sequencer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CW       = 11
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  gray_roi_sequencer_if.slave      bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FRAME = 2'd1;
  localparam logic [1:0] S_OVF   = 2'd2;

  localparam int            NPIX   = H_ACTIVE * V_ACTIVE;
  localparam int            PW     = $clog2(NPIX + 1);
  localparam logic [PW-1:0] NPIX_C = PW'(NPIX);
  localparam logic [CW-1:0] X_LAST = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] Y_END  = CW'(V_ACTIVE);

  logic [1:0]    state_q, state_d;
  logic          fval_q, fval_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic [CW-1:0] sx0_q, sx0_d, sx1_q, sx1_d, sy0_q, sy0_d, sy1_q, sy1_d;
  logic          sh_full_q, sh_full_d;
  logic          gray_dval_q, gray_dval_d;
  logic [29:0]   pix_q, pix_d;
  logic [CW-1:0] ox_q, ox_d, oy_q, oy_d;
  logic          sof_q, sof_d, eof_q, eof_d;
  logic [15:0]   fcnt_q, fcnt_d;
  logic          err_q, err_d;

  logic          fval_rise, fval_fall;
  logic          take;
  logic [CW-1:0] px, py;
  logic [PW-1:0] cnt_base;

  assign fval_rise = bus.iFVAL & ~fval_q;
  assign fval_fall = ~bus.iFVAL & fval_q;

  always_comb begin
    state_d     = state_q;
    fval_d      = bus.iFVAL;
    x_d         = x_q;
    y_d         = y_q;
    cnt_d       = cnt_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    y0_d        = y0_q;
    y1_d        = y1_q;
    sx0_d       = sx0_q;
    sx1_d       = sx1_q;
    sy0_d       = sy0_q;
    sy1_d       = sy1_q;
    sh_full_d   = sh_full_q;
    gray_dval_d = 1'b0;
    pix_d       = pix_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    sof_d       = 1'b0;
    eof_d       = 1'b0;
    fcnt_d      = fcnt_q;
    err_d       = err_q;
    take        = 1'b0;
    px          = x_q;
    py          = y_q;
    cnt_base    = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (fval_rise) begin
          if (sh_full_q) begin
            x0_d      = sx0_q;
            x1_d      = sx1_q;
            y0_d      = sy0_q;
            y1_d      = sy1_q;
            sh_full_d = 1'b0;
          end
          x_d     = '0;
          y_d     = '0;
          cnt_d   = '0;
          sof_d   = 1'b1;
          state_d = S_FRAME;
          // A pixel on the rising-edge cycle is (0,0) of the new frame.
          if (bus.iDVAL) begin
            take     = 1'b1;
            px       = '0;
            py       = '0;
            cnt_base = '0;
          end
        end
      end
      S_FRAME: begin
        if (fval_fall) begin
          if (cnt_q == NPIX_C) begin
            eof_d  = 1'b1;
            fcnt_d = fcnt_q + 16'd1;
          end else begin
            err_d = 1'b1;
          end
          state_d = S_IDLE;
        end else if (bus.iFVAL && bus.iDVAL) begin
          // Y already past the last line means this pixel is one too many.
          if (y_q == Y_END) begin
            err_d   = 1'b1;
            state_d = S_OVF;
          end else begin
            take = 1'b1;
          end
        end
      end
      S_OVF: begin
        if (fval_fall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (take) begin
      pix_d = bus.iPIX;
      ox_d  = px;
      oy_d  = py;
      // Compare against the *_d bounds so a shadow applied this cycle
      // already governs pixel (0,0).
      gray_dval_d = (px >= x0_d) && (px <= x1_d) && (py >= y0_d) && (py <= y1_d);
      if (px == X_LAST) begin
        x_d = '0;
        y_d = py + CW'(1);
      end else begin
        x_d = px + CW'(1);
      end
      cnt_d = cnt_base + PW'(1);
    end

    // Shadow is only writable while empty, so this never collides with the
    // apply above (apply needs sh_full_q=1).
    if (bus.iCFG_VALID && !sh_full_q) begin
      sx0_d     = bus.iCFG_X0;
      sx1_d     = bus.iCFG_X1;
      sy0_d     = bus.iCFG_Y0;
      sy1_d     = bus.iCFG_Y1;
      sh_full_d = 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q     <= S_IDLE;
      fval_q      <= 1'b1;   // an iFVAL already high at release is not a frame start
      x_q         <= '0;
      y_q         <= '0;
      cnt_q       <= '0;
      x0_q        <= '0;
      x1_q        <= X_LAST;
      y0_q        <= '0;
      y1_q        <= CW'(V_ACTIVE - 1);
      sx0_q       <= '0;
      sx1_q       <= '0;
      sy0_q       <= '0;
      sy1_q       <= '0;
      sh_full_q   <= 1'b0;
      gray_dval_q <= 1'b0;
      pix_q       <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      fcnt_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fval_q      <= fval_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cnt_q       <= cnt_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      y0_q        <= y0_d;
      y1_q        <= y1_d;
      sx0_q       <= sx0_d;
      sx1_q       <= sx1_d;
      sy0_q       <= sy0_d;
      sy1_q       <= sy1_d;
      sh_full_q   <= sh_full_d;
      gray_dval_q <= gray_dval_d;
      pix_q       <= pix_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      fcnt_q      <= fcnt_d;
      err_q       <= err_d;
    end
  end

  assign bus.oCFG_READY = ~sh_full_q;
  assign bus.oGRAY_DVAL = gray_dval_q;
  assign bus.oPIX       = pix_q;
  assign bus.oX         = ox_q;
  assign bus.oY         = oy_q;
  assign bus.oSOF       = sof_q;
  assign bus.oEOF       = eof_q;
  assign bus.oFRAME_CNT = fcnt_q;
  assign bus.oERR       = err_q;

endmodule

// File: tb/tb_gray_roi_sequencer.sv
module tb_gray_roi_sequencer;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int CW = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  gray_roi_sequencer_if #(.CW(CW)) ifc();

  gray_roi_sequencer #(.H_ACTIVE(H), .V_ACTIVE(V), .CW(CW)) dut (
    .iCLK (clk),
    .iRST (rst_n),
    .bus  (ifc)
  );

  int tests = 0;
  int fails = 0;
  logic [51:0] exp_q[$];
  int sof_seen = 0, eof_seen = 0, sof_exp = 0, eof_exp = 0;

  // Reference model: active ROI, shadow ROI, good-frame count, error flag.
  int roi[4];
  int sh[4];
  bit m_full;
  int m_fcnt;
  bit m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic bit in_roi(input int x, input int y);
    return (x >= roi[0]) && (x <= roi[1]) && (y >= roi[2]) && (y <= roi[3]);
  endfunction

  task automatic model_reset();
    roi[0] = 0; roi[1] = H - 1; roi[2] = 0; roi[3] = V - 1;
    m_full = 0;
    m_fcnt = 0;
    m_err  = 0;
    exp_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle(input int n);
    repeat (n) begin
      ifc.iFVAL      = 1'b0;
      ifc.iDVAL      = 1'($urandom_range(0, 1));
      ifc.iPIX       = 30'($urandom);
      ifc.iCFG_VALID = 1'b0;
      tick();
    end
  endtask

  // Presents a config write this cycle; the model accepts it iff ready.
  task automatic set_cfg(input int a, input int b, input int c, input int d, input bit ready_exp);
    ifc.iCFG_VALID = 1'b1;
    ifc.iCFG_X0 = CW'(a);
    ifc.iCFG_X1 = CW'(b);
    ifc.iCFG_Y0 = CW'(c);
    ifc.iCFG_Y1 = CW'(d);
    chk("cfg_ready_at_write", 64'(ifc.oCFG_READY), 64'(ready_exp));
    if (ready_exp) begin
      sh[0] = a; sh[1] = b; sh[2] = c; sh[3] = d;
      m_full = 1;
    end
  endtask

  task automatic check_frame_end(input string tag);
    chk({tag, "_frame_cnt"}, 64'(ifc.oFRAME_CNT), 64'(m_fcnt));
    chk({tag, "_err"}, 64'(ifc.oERR), 64'(m_err));
    chk({tag, "_sof_count"}, 64'(sof_seen), 64'(sof_exp));
    chk({tag, "_eof_count"}, 64'(eof_seen), 64'(eof_exp));
    chk({tag, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_cfg_ready"}, 64'(ifc.oCFG_READY), 64'(!m_full));
  endtask

  // One frame of n pixels with random blanking; optional config write at
  // frame cycle cfg_at (cycle 0 is the iFVAL rising-edge cycle).
  task automatic run_frame(input string tag, input int n, input int cfg_at,
                           input int c0, input int c1, input int c2, input int c3);
    bit was_full;
    int k, cyc;
    was_full = m_full;
    k = 0;
    cyc = 0;
    sof_exp++;
    if (m_full) begin
      roi = sh;
      m_full = 0;
    end
    while (k < n) begin
      ifc.iFVAL = 1'b1;
      ifc.iPIX  = 30'($urandom);
      ifc.iDVAL = (cyc == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) != 0);
      ifc.iCFG_VALID = 1'b0;
      if (cyc == cfg_at) set_cfg(c0, c1, c2, c3, (cyc == 0) ? !was_full : !m_full);
      if (ifc.iDVAL) begin
        if (k < H * V && in_roi(k % H, k / H))
          exp_q.push_back({ifc.iPIX, CW'(k % H), CW'(k / H)});
        k++;
      end
      tick();
      cyc++;
    end
    repeat ($urandom_range(0, 2)) begin
      ifc.iFVAL = 1'b1;
      ifc.iDVAL = 1'b0;
      ifc.iCFG_VALID = 1'b0;
      tick();
    end
    // Falling-edge cycle: any pixel here must be ignored.
    ifc.iFVAL = 1'b0;
    ifc.iDVAL = 1'($urandom_range(0, 1));
    ifc.iPIX  = 30'($urandom);
    ifc.iCFG_VALID = 1'b0;
    tick();
    if (n == H * V) begin
      eof_exp++;
      m_fcnt = (m_fcnt + 1) & 16'hFFFF;
    end else begin
      m_err = 1;
    end
    drive_idle(2);
    check_frame_end(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_outputs_zero"},
        64'({ifc.oGRAY_DVAL, ifc.oPIX, ifc.oX, ifc.oY, ifc.oSOF, ifc.oEOF, ifc.oFRAME_CNT, ifc.oERR}),
        64'd0);
    chk({tag, "_cfg_ready"}, 64'(ifc.oCFG_READY), 64'd1);
  endtask

  // Monitor: pops one expected pixel per forwarded oGRAY_DVAL.
  always @(negedge clk) begin
    logic [51:0] e;
    if (rst_n) begin
      if (ifc.oSOF) sof_seen++;
      if (ifc.oEOF) eof_seen++;
      if (ifc.oGRAY_DVAL) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_gray_dval", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("pixel_xy", 64'({ifc.oPIX, ifc.oX, ifc.oY}), 64'(e));
        end
      end
    end
  end

  initial begin
    int n, cfg_at;
    int nsel[5];
    nsel[0] = 7; nsel[1] = 8; nsel[2] = 8; nsel[3] = 8; nsel[4] = 9;

    ifc.iFVAL = 1'b0;
    ifc.iDVAL = 1'b0;
    ifc.iPIX  = '0;
    ifc.iCFG_VALID = 1'b0;
    ifc.iCFG_X0 = '0; ifc.iCFG_X1 = '0; ifc.iCFG_Y0 = '0; ifc.iCFG_Y1 = '0;

    #2 rst_n = 1'b0;
    #10;
    model_reset();
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive_idle(2);

    // Default ROI, then ROI (1..2,1..1) written mid-frame, applied next SOF.
    run_frame("default_roi", 8, 2, 1, 2, 1, 1);
    run_frame("small_roi", 8, -1, 0, 0, 0, 0);
    // Restore full window for the next frames.
    set_cfg(0, H - 1, 0, V - 1, !m_full);
    tick();
    ifc.iCFG_VALID = 1'b0;
    run_frame("short_frame", 7, -1, 0, 0, 0, 0);
    run_frame("good_after_err", 8, -1, 0, 0, 0, 0);
    run_frame("long_frame", 9, -1, 0, 0, 0, 0);

    // Randomized frames, sizes and ROI writes (including empty/clipped windows).
    for (int i = 0; i < 24; i++) begin
      n = nsel[$urandom_range(0, 4)];
      cfg_at = int'($urandom_range(0, 5)) - 2;
      run_frame("random", n, cfg_at, $urandom_range(0, 5), $urandom_range(0, 5),
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset at pixel 5 with a pending shadow write, iFVAL held across release.
    set_cfg(1, 1, 0, 0, !m_full);
    tick();
    ifc.iCFG_VALID = 1'b0;
    sof_exp++;
    if (m_full) begin
      roi = sh;
      m_full = 0;
    end
    for (int k = 0; k < 5; k++) begin
      ifc.iFVAL = 1'b1;
      ifc.iDVAL = 1'b1;
      ifc.iPIX  = 30'($urandom);
      ifc.iCFG_VALID = 1'b0;
      if (k == 1) set_cfg(2, 3, 1, 1, !m_full);
      if (in_roi(k % H, k / H)) exp_q.push_back({ifc.iPIX, CW'(k % H), CW'(k / H)});
      tick();
    end
    ifc.iDVAL = 1'b0;
    ifc.iCFG_VALID = 1'b0;
    tick();
    chk("pre_reset_queue_drained", 64'(exp_q.size()), 64'd0);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("midframe_reset");
    model_reset();
    ifc.iDVAL = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ifc.iFVAL = 1'b1;
      ifc.iDVAL = 1'($urandom_range(0, 1));
      ifc.iPIX  = 30'($urandom);
      tick();
    end
    chk("no_sof_while_fval_held", 64'(sof_seen), 64'(sof_exp));
    drive_idle(3);
    chk("no_eof_on_stale_fall", 64'(eof_seen), 64'(eof_exp));
    run_frame("after_reset", 8, -1, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
